// File: rtl/launch_command_parser_if.sv
// Command/result bundle between the keyboard-side source and the launch command parser.
// The master drives decoded characters; the slave returns committed launch settings.
interface launch_command_parser_if;
  logic [7:0] input_character;
  logic       input_made;
  logic [7:0] velocity;
  logic [7:0] angle;
  logic       fire;
  logic       busy;
  logic [1:0] mode;
  logic [9:0] entry_value;
  logic       cmd_error;

  modport master (
    output input_character, input_made,
    input  velocity, angle, fire, busy, mode, entry_value, cmd_error
  );

  modport slave (
    input  input_character, input_made,
    output velocity, angle, fire, busy, mode, entry_value, cmd_error
  );
endinterface

// File: rtl/launch_command_parser.sv
// Parses typed V/A/digit/Enter/F commands into velocity and angle settings plus a rate-limited fire.
// Optional macro ANGLE_CLAMP_EN limits committed angles to 180 degrees instead of 255.
module launch_command_parser #(
  parameter int unsigned COOLDOWN_CYCLES = 32'd50_000_000,
  parameter logic [7:0]  VEL_RESET       = 8'd0,
  parameter logic [7:0]  ANG_RESET       = 8'd90
) (
  input logic                     clock,
  input logic                     reset,
  launch_command_parser_if.slave  cmd_if
);

  typedef enum logic [1:0] {StIdle = 2'b00, StVel = 2'b01, StAng = 2'b10} state_e;

  // A zero cooldown degenerates to "never busy" rather than wrapping the counter.
  localparam logic [31:0] CoolLoad = (COOLDOWN_CYCLES == 0) ? 32'd0 : COOLDOWN_CYCLES - 32'd1;

`ifdef ANGLE_CLAMP_EN
  localparam logic [9:0] AngMax = 10'd180;
`else
  localparam logic [9:0] AngMax = 10'd255;
`endif

  state_e      state_q, state_d;
  logic [9:0]  acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  vel_q, vel_d;
  logic [7:0]  ang_q, ang_d;
  logic        fire_q, fire_d;
  logic        err_q, err_d;
  logic [31:0] cool_q, cool_d;

  logic [7:0] ch;
  logic       is_vel, is_ang, is_digit, is_enter, is_bs, is_fire, busy;
  logic [7:0] clamp_vel, clamp_ang;

  assign ch       = cmd_if.input_character;
  assign is_vel   = cmd_if.input_made && (ch == 8'h56 || ch == 8'h76);
  assign is_ang   = cmd_if.input_made && (ch == 8'h41 || ch == 8'h61);
  assign is_digit = cmd_if.input_made && (ch >= 8'h30) && (ch <= 8'h39);
  assign is_enter = cmd_if.input_made && (ch == 8'h0D);
  assign is_bs    = cmd_if.input_made && (ch == 8'h08);
  assign is_fire  = cmd_if.input_made && (ch == 8'h46 || ch == 8'h66);
  assign busy     = (cool_q != 32'd0);

  assign clamp_vel = (acc_q > 10'd255) ? 8'd255 : acc_q[7:0];
  assign clamp_ang = (acc_q > AngMax) ? AngMax[7:0] : acc_q[7:0];

  // State register and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= 10'd0;
      cnt_q   <= 2'd0;
      vel_q   <= VEL_RESET;
      ang_q   <= ANG_RESET;
      fire_q  <= 1'b0;
      err_q   <= 1'b0;
      cool_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      vel_q   <= vel_d;
      ang_q   <= ang_d;
      fire_q  <= fire_d;
      err_q   <= err_d;
      cool_q  <= cool_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (is_vel) begin
      state_d = StVel;
    end else if (is_ang) begin
      state_d = StAng;
    end else if (is_enter) begin
      state_d = StIdle;
    end
  end

  // Datapath next values; the cooldown counter runs independently of the command FSM.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    vel_d  = vel_q;
    ang_d  = ang_q;
    fire_d = 1'b0;
    err_d  = 1'b0;
    cool_d = busy ? cool_q - 32'd1 : cool_q;
    if (is_vel || is_ang || is_bs) begin
      acc_d = 10'd0;
      cnt_d = 2'd0;
    end else if (is_digit) begin
      if (state_q != StIdle && cnt_q != 2'd3) begin
        acc_d = acc_q * 10'd10 + {6'd0, ch[3:0]};
        cnt_d = cnt_q + 2'd1;
      end else begin
        err_d = 1'b1;
      end
    end else if (is_enter && state_q != StIdle) begin
      acc_d = 10'd0;
      cnt_d = 2'd0;
      if (cnt_q == 2'd0) begin
        err_d = 1'b1;
      end else if (state_q == StVel) begin
        vel_d = clamp_vel;
      end else begin
        ang_d = clamp_ang;
      end
    end else if (is_fire) begin
      if (state_q == StIdle && !busy) begin
        fire_d = 1'b1;
        cool_d = CoolLoad;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    cmd_if.mode        = state_q;
    cmd_if.velocity    = vel_q;
    cmd_if.angle       = ang_q;
    cmd_if.entry_value = acc_q;
    cmd_if.fire        = fire_q;
    cmd_if.cmd_error   = err_q;
    cmd_if.busy        = busy;
  end

endmodule

// File: tb/tb_launch_command_parser.sv
// Self-checking bench for launch_command_parser: directed scenarios plus randomized
// keystrokes against a time-based behavioural model.
module tb_launch_command_parser;
  localparam int C = 10;

  logic clock = 1'b0;
  logic reset;
  launch_command_parser_if cmd_if ();

  launch_command_parser #(
    .COOLDOWN_CYCLES(C),
    .VEL_RESET(8'd0),
    .ANG_RESET(8'd90)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .cmd_if (cmd_if)
  );

  always #5 clock = ~clock;

`ifdef ANGLE_CLAMP_EN
  localparam int AngLim = 180;
`else
  localparam int AngLim = 255;
`endif

  int total = 0;
  int bad = 0;
  int n = 0;

  // Model state: mode 0 idle, 1 velocity entry, 2 angle entry.
  int m_mode, m_acc, m_dig, m_vel, m_ang;
  bit m_fire, m_err, m_busy, have_fire;
  int last_fire;

  task automatic model_char(input logic [7:0] ch);
    if (ch == "V" || ch == "v") begin
      m_mode = 1; m_acc = 0; m_dig = 0;
    end else if (ch == "A" || ch == "a") begin
      m_mode = 2; m_acc = 0; m_dig = 0;
    end else if (ch >= "0" && ch <= "9") begin
      if (m_mode != 0 && m_dig < 3) begin
        m_acc = m_acc * 10 + int'(ch - "0");
        m_dig++;
      end else m_err = 1;
    end else if (ch == 8'h0D) begin
      if (m_mode != 0) begin
        if (m_dig == 0) m_err = 1;
        else if (m_mode == 1) m_vel = (m_acc > 255) ? 255 : m_acc;
        else m_ang = (m_acc > AngLim) ? AngLim : m_acc;
        m_mode = 0; m_acc = 0; m_dig = 0;
      end
    end else if (ch == 8'h08) begin
      m_acc = 0; m_dig = 0;
    end else if (ch == "F" || ch == "f") begin
      if (m_mode == 0 && !(have_fire && (n - last_fire) < C)) begin
        m_fire = 1; have_fire = 1; last_fire = n;
      end else m_err = 1;
    end
  endtask

  task automatic tick(input bit made, input logic [7:0] ch);
    cmd_if.input_made = made;
    cmd_if.input_character = ch;
    @(posedge clock);
    n++;
    m_fire = 0; m_err = 0;
    if (made) model_char(ch);
    m_busy = have_fire && (n - last_fire) < C - 1;
    @(negedge clock);
    cmd_if.input_made = 1'b0;
  endtask

  task automatic tick_reset(input bit made, input logic [7:0] ch);
    reset = 1'b1;
    cmd_if.input_made = made;
    cmd_if.input_character = ch;
    @(posedge clock);
    n++;
    m_mode = 0; m_acc = 0; m_dig = 0; m_vel = 0; m_ang = 90;
    m_fire = 0; m_err = 0; m_busy = 0; have_fire = 0;
    @(negedge clock);
    reset = 1'b0;
    cmd_if.input_made = 1'b0;
  endtask

  task automatic test_reset;
    tick_reset(1'b0, 8'h00);
    total += 7;
    if (cmd_if.velocity !== 8'd0) begin bad++; $display("FAIL rst_vel got=%0d want=0", cmd_if.velocity); end
    if (cmd_if.angle !== 8'd90) begin bad++; $display("FAIL rst_ang got=%0d want=90", cmd_if.angle); end
    if (cmd_if.mode !== 2'd0) begin bad++; $display("FAIL rst_mode got=%0d want=0", cmd_if.mode); end
    if (cmd_if.entry_value !== 10'd0) begin bad++; $display("FAIL rst_entry got=%0d want=0", cmd_if.entry_value); end
    if (cmd_if.fire !== 1'b0) begin bad++; $display("FAIL rst_fire got=%0b want=0", cmd_if.fire); end
    if (cmd_if.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", cmd_if.busy); end
    if (cmd_if.cmd_error !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b want=0", cmd_if.cmd_error); end
  endtask

  task automatic test_velocity;
    logic [7:0] seq [5] = '{"V", "1", "2", "0", 8'h0D};
    bit any_err = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, seq[i]);
      if (i == 3) begin
        total++;
        if (cmd_if.entry_value !== 10'd120) begin bad++; $display("FAIL vel_echo got=%0d want=120", cmd_if.entry_value); end
      end
      any_err |= cmd_if.cmd_error;
    end
    total += 4;
    if (cmd_if.velocity !== 8'd120) begin bad++; $display("FAIL vel_commit got=%0d want=120", cmd_if.velocity); end
    if (cmd_if.mode !== 2'd0) begin bad++; $display("FAIL vel_mode got=%0d want=0", cmd_if.mode); end
    if (cmd_if.entry_value !== 10'd0) begin bad++; $display("FAIL vel_entry got=%0d want=0", cmd_if.entry_value); end
    if (any_err !== 1'b0) begin bad++; $display("FAIL vel_err got=%0b want=0", any_err); end
  endtask

  task automatic test_angle;
    logic [7:0] seq [5] = '{"A", "2", "5", "0", 8'h0D};
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, seq[i]);
      if (i == 0) begin
        total++;
        if (cmd_if.mode !== 2'd2) begin bad++; $display("FAIL ang_mode got=%0d want=2", cmd_if.mode); end
      end
    end
    total++;
    if (int'(cmd_if.angle) !== ((AngLim == 180) ? 180 : 250)) begin
      bad++; $display("FAIL ang_commit got=%0d want=%0d", cmd_if.angle, (AngLim == 180) ? 180 : 250);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] seq [6] = '{"v", "9", "9", "9", "9", 8'h0D};
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, seq[i]);
      total++;
      if (cmd_if.cmd_error !== (i == 4)) begin
        bad++; $display("FAIL ovf_err[%0d] got=%0b want=%0b", i, cmd_if.cmd_error, i == 4);
      end
    end
    total++;
    if (cmd_if.velocity !== 8'd255) begin bad++; $display("FAIL ovf_vel got=%0d want=255", cmd_if.velocity); end
  endtask

  task automatic test_backspace;
    logic [7:0] seq [5] = '{"V", "5", 8'h08, "7", 8'h0D};
    for (int i = 0; i < 5; i++) tick(1'b1, seq[i]);
    total++;
    if (cmd_if.velocity !== 8'd7) begin bad++; $display("FAIL bs_vel got=%0d want=7", cmd_if.velocity); end
    tick(1'b1, "V");
    tick(1'b1, 8'h0D);
    total += 3;
    if (cmd_if.cmd_error !== 1'b1) begin bad++; $display("FAIL empty_enter_err got=%0b want=1", cmd_if.cmd_error); end
    if (cmd_if.velocity !== 8'd7) begin bad++; $display("FAIL empty_enter_vel got=%0d want=7", cmd_if.velocity); end
    if (cmd_if.mode !== 2'd0) begin bad++; $display("FAIL empty_enter_mode got=%0d want=0", cmd_if.mode); end
    tick(1'b1, 8'h0D);
    total++;
    if (cmd_if.cmd_error !== 1'b0) begin bad++; $display("FAIL idle_enter_err got=%0b want=0", cmd_if.cmd_error); end
  endtask

  task automatic test_cooldown;
    tick_reset(1'b0, 8'h00);
    tick(1'b1, "F");
    total += 2;
    if (cmd_if.fire !== 1'b1) begin bad++; $display("FAIL cd_fire1 got=%0b want=1", cmd_if.fire); end
    if (cmd_if.busy !== 1'b1) begin bad++; $display("FAIL cd_busy1 got=%0b want=1", cmd_if.busy); end
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00);
    tick(1'b1, "f");
    total += 2;
    if (cmd_if.fire !== 1'b0) begin bad++; $display("FAIL cd_fire2 got=%0b want=0", cmd_if.fire); end
    if (cmd_if.cmd_error !== 1'b1) begin bad++; $display("FAIL cd_err2 got=%0b want=1", cmd_if.cmd_error); end
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00);
    total++;
    if (cmd_if.busy !== 1'b0) begin bad++; $display("FAIL cd_busy_end got=%0b want=0", cmd_if.busy); end
    tick(1'b1, "F");
    total += 2;
    if (cmd_if.fire !== 1'b1) begin bad++; $display("FAIL cd_fire3 got=%0b want=1", cmd_if.fire); end
    if (cmd_if.cmd_error !== 1'b0) begin bad++; $display("FAIL cd_err3 got=%0b want=0", cmd_if.cmd_error); end
    tick(1'b1, "V");
    tick(1'b1, "F");
    total++;
    if (cmd_if.cmd_error !== 1'b1) begin bad++; $display("FAIL fire_not_idle got=%0b want=1", cmd_if.cmd_error); end
  endtask

  task automatic test_reset_collision;
    tick_reset(1'b0, 8'h00);
    tick(1'b1, "A");
    tick(1'b1, "4");
    tick_reset(1'b1, "7");
    total += 3;
    if (cmd_if.angle !== 8'd90) begin bad++; $display("FAIL coll_ang got=%0d want=90", cmd_if.angle); end
    if (cmd_if.mode !== 2'd0) begin bad++; $display("FAIL coll_mode got=%0d want=0", cmd_if.mode); end
    if (cmd_if.entry_value !== 10'd0) begin bad++; $display("FAIL coll_entry got=%0d want=0", cmd_if.entry_value); end
  endtask

  task automatic test_random;
    logic [7:0] pool [20] = '{"V", "v", "A", "a", "0", "1", "2", "3", "4", "5",
                              "6", "7", "8", "9", 8'h0D, 8'h0D, 8'h08, "F", "f", "x"};
    logic [7:0] ch;
    bit made;
    for (int i = 0; i < 400; i++) begin
      made = ($urandom_range(0, 3) != 0);
      ch = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
      tick(made, ch);
      total += 7;
      if (int'(cmd_if.velocity) !== m_vel) begin bad++; $display("FAIL rnd_vel @%0d got=%0d want=%0d", i, cmd_if.velocity, m_vel); end
      if (int'(cmd_if.angle) !== m_ang) begin bad++; $display("FAIL rnd_ang @%0d got=%0d want=%0d", i, cmd_if.angle, m_ang); end
      if (int'(cmd_if.mode) !== m_mode) begin bad++; $display("FAIL rnd_mode @%0d got=%0d want=%0d", i, cmd_if.mode, m_mode); end
      if (int'(cmd_if.entry_value) !== m_acc) begin bad++; $display("FAIL rnd_entry @%0d got=%0d want=%0d", i, cmd_if.entry_value, m_acc); end
      if (cmd_if.fire !== m_fire) begin bad++; $display("FAIL rnd_fire @%0d got=%0b want=%0b", i, cmd_if.fire, m_fire); end
      if (cmd_if.busy !== m_busy) begin bad++; $display("FAIL rnd_busy @%0d got=%0b want=%0b", i, cmd_if.busy, m_busy); end
      if (cmd_if.cmd_error !== m_err) begin bad++; $display("FAIL rnd_err @%0d got=%0b want=%0b", i, cmd_if.cmd_error, m_err); end
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_if.input_made = 1'b0;
    cmd_if.input_character = 8'h00;
    @(negedge clock);
    test_reset();
    test_velocity();
    test_angle();
    test_overflow();
    test_backspace();
    test_cooldown();
    test_reset_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
